// File: rtl/rvc_compressor_packer.sv
// ============================================================================
//  Module : rvc_compressor_packer
//  Brief  : Streaming RV32I->RVC compressor that packs halfwords into 32-bit words.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvc_compressor_packer #(
    parameter int CNT_W       = 16,
    parameter bit COMPRESS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             idle,
    output logic [CNT_W-1:0] count_compressed
);

    localparam logic [6:0]  c_OP_IMM  = 7'b0010011;
    localparam logic [6:0]  c_OP      = 7'b0110011;
    localparam logic [6:0]  c_LOAD    = 7'b0000011;
    localparam logic [6:0]  c_STORE   = 7'b0100011;
    localparam logic [15:0] c_CNOP    = 16'h0001;

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [11:0] w_imm_i, w_imm_s;
    logic        w_small_imm, w_rd_c, w_rs1_c, w_rs2_c;
    logic        w_is_addi, w_is_add, w_is_lw, w_is_sw;
    logic        w_cvalid;
    logic [15:0] w_chalf;
    logic [1:0]  w_f2;
    logic        w_f2_ok;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_f3     = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = in_instr[31:20];
    assign w_imm_s  = {in_instr[31:25], in_instr[11:7]};

    // Immediate fits in 6-bit signed when bits [11:5] are a pure sign extension.
    assign w_small_imm = (w_imm_i[11:5] == {7{w_imm_i[5]}});
    assign w_rd_c      = (w_rd[4:3]  == 2'b01);
    assign w_rs1_c     = (w_rs1[4:3] == 2'b01);
    assign w_rs2_c     = (w_rs2[4:3] == 2'b01);

    assign w_is_addi = (w_opcode == c_OP_IMM) && (w_f3 == 3'b000);
    assign w_is_add  = (w_opcode == c_OP) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
    assign w_is_lw   = (w_opcode == c_LOAD)  && (w_f3 == 3'b010);
    assign w_is_sw   = (w_opcode == c_STORE) && (w_f3 == 3'b010);

    always_comb begin
        w_f2    = 2'b00;
        w_f2_ok = 1'b0;
        if (w_opcode == c_OP) begin
            if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                w_f2 = 2'b00; w_f2_ok = 1'b1;
            end else if (w_f7 == 7'b0000000 && w_f3 == 3'b100) begin
                w_f2 = 2'b01; w_f2_ok = 1'b1;
            end else if (w_f7 == 7'b0000000 && w_f3 == 3'b110) begin
                w_f2 = 2'b10; w_f2_ok = 1'b1;
            end else if (w_f7 == 7'b0000000 && w_f3 == 3'b111) begin
                w_f2 = 2'b11; w_f2_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_cvalid = 1'b0;
        w_chalf  = 16'h0000;
        if (!COMPRESS_EN) begin
            w_cvalid = 1'b0;
        end else if (w_is_addi && w_rs1 == 5'd0 && w_rd != 5'd0 && w_small_imm) begin
            w_cvalid = 1'b1;
            w_chalf  = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
        end else if (w_is_addi && w_rs1 == w_rd && w_rd != 5'd0 && w_imm_i != 12'd0 && w_small_imm) begin
            w_cvalid = 1'b1;
            w_chalf  = {3'b000, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
        end else if (w_is_add && w_rs1 == 5'd0 && w_rd != 5'd0 && w_rs2 != 5'd0) begin
            w_cvalid = 1'b1;
            w_chalf  = {4'b1000, w_rd, w_rs2, 2'b10};
        end else if (w_is_add && w_rs1 == w_rd && w_rd != 5'd0 && w_rs2 != 5'd0) begin
            w_cvalid = 1'b1;
            w_chalf  = {4'b1001, w_rd, w_rs2, 2'b10};
        end else if (w_f2_ok && w_rs1 == w_rd && w_rd_c && w_rs2_c) begin
            w_cvalid = 1'b1;
            w_chalf  = {6'b100011, w_rd[2:0], w_f2, w_rs2[2:0], 2'b01};
        end else if (w_is_lw && w_rd_c && w_rs1_c && w_imm_i[11:7] == 5'd0 && w_imm_i[1:0] == 2'b00) begin
            w_cvalid = 1'b1;
            w_chalf  = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6], w_rd[2:0], 2'b00};
        end else if (w_is_sw && w_rs2_c && w_rs1_c && w_imm_s[11:7] == 5'd0 && w_imm_s[1:0] == 2'b00) begin
            w_cvalid = 1'b1;
            w_chalf  = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6], w_rs2[2:0], 2'b00};
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_word_q, out_word_d;
    logic             pend_q, pend_d;
    logic [15:0]      half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_accept, w_flush;

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    // An accepted input takes priority over flush in the same cycle.
    assign w_flush  = flush && in_ready && !w_accept && pend_q;

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_word_d  = out_word_q;
        pend_d      = pend_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        if (w_accept) begin
            if (w_cvalid) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pend_q) begin
                    out_word_d  = {w_chalf, half_q};
                    out_valid_d = 1'b1;
                    pend_d      = 1'b0;
                end else begin
                    half_d = w_chalf;
                    pend_d = 1'b1;
                end
            end else if (pend_q) begin
                out_word_d  = {in_instr[15:0], half_q};
                out_valid_d = 1'b1;
                half_d      = in_instr[31:16];
            end else begin
                out_word_d  = in_instr;
                out_valid_d = 1'b1;
            end
        end else if (w_flush) begin
            out_word_d  = {c_CNOP, half_q};
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0;
            pend_q      <= 1'b0;
            half_q      <= 16'h0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            pend_q      <= pend_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_word         = out_word_q;
    assign idle             = !pend_q && !out_valid_q;
    assign count_compressed = cnt_q;

endmodule

`default_nettype wire

// File: doc/rvc_compressor_packer.md
Name: rvc_compressor_packer

Overview:
- Streaming RV32I to RVC compressor for the program-image path. It is the inverse of the instruction decompressor.
- Accepts one 32-bit instruction per handshake and replaces a fixed subset with its 16-bit RVC encoding.
- Packs the resulting halfword stream into little-endian 32-bit memory words for the program memory writer.
- Holds at most one leftover halfword; a flush pads it with C.NOP.

Parameters:
- CNT_W, 16, width of the compressed-instruction counter.
- COMPRESS_EN, 1, when 0 every instruction passes through uncompressed (packing logic still active).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_instr valid
- in_ready  output  1  block can accept in_instr this cycle
- in_instr  input  32  uncompressed RV32I instruction
- flush  input  1  request to emit any pending halfword; held until idle=1
- out_valid  output  1  out_word valid
- out_ready  input  1  consumer accepts out_word
- out_word  output  32  packed word; bits [15:0] hold the earlier halfword
- idle  output  1  no pending halfword and no valid output
- count_compressed  output  CNT_W  number of instructions emitted in 16-bit form

Behaviour:
Reset and handshake
- Reset (async, reset_n=0) clears: out_valid=0, out_word=0, pending-valid=0, pending halfword=0, count_compressed=0. idle=1 after reset.
- A reset asserted mid-stream discards any pending halfword and any unaccepted out_word.
- in_ready = !out_valid || out_ready (combinational).
- An input is accepted when in_valid && in_ready.
- out_word/out_valid are registered and stay stable while out_valid && !out_ready.
- Each accepted input or flush produces at most one output word. Latency from accept to out_valid is 1 cycle whenever a word completes.

Compression rules (checked in order; the first match wins; otherwise the instruction is not compressible)
- C.LI: ADDI rd,x0,imm; rd!=0; imm in [-32,31]. Encoding 010|imm[5]|rd|imm[4:0]|01.
- C.ADDI: ADDI rd,rd,imm; rd!=0; imm!=0; imm in [-32,31]. Encoding 000|imm[5]|rd|imm[4:0]|01.
- C.MV: ADD rd,x0,rs2; rd!=0; rs2!=0. Encoding 100|0|rd|rs2|10.
- C.ADD: ADD rd,rd,rs2; rd!=0; rs2!=0. Encoding 100|1|rd|rs2|10.
- C.SUB/C.XOR/C.OR/C.AND: op rd,rd,rs2; rd and rs2 in x8..x15. Encoding 100|0|11|rd'|f2|rs2'|01, with f2: SUB=00, XOR=01, OR=10, AND=11.
- C.LW: LW rd,off(rs1); rd and rs1 in x8..x15; off%4==0; off in [0,124]. Encoding 010|off[5:3]|rs1'|off[2]|off[6]|rd'|00.
- C.SW: SW rs2,off(rs1); same constraints as C.LW. Encoding 110|off[5:3]|rs1'|off[2]|off[6]|rs2'|00.
- Compressed-register field: r' = r-8 (3 bits).
- COMPRESS_EN=0 disables all rules.

Packing state (P = pending-valid, H = pending halfword)
- P=0, compressed c: set H=c, P=1; no output.
- P=1, compressed c: out_word={c,H}; set P=0.
- P=0, uncompressed i: out_word=i; P stays 0.
- P=1, uncompressed i: out_word={i[15:0],H}; set H=i[31:16], P stays 1.
- count_compressed increments on each accepted compressible input and wraps modulo 2^CNT_W.

Flush
- Acted on only in a cycle with in_ready=1 and no input accepted. An input accepted in the same cycle has priority, and flush is re-evaluated next cycle.
- P=1: out_word={16'h0001,H}, P=0.
- P=0: no effect.
- idle = !P && !out_valid.

Test Plan:
- Two accepted addi x8,x8,1 (0x00140413) -> one out_word=0x04050405; count_compressed=2.
- li x10,5 (0x00500513) then flush -> out_word=0x00014515; then idle=1.
- addi x8,x8,1 then lui x5,0x12345 (0x123452B7) then flush -> out_word 0x52B70405, then 0x00011234.
- lw x9,8(x10) (0x00852483) twice -> out_word=0x45044504. addi x8,x8,32 (0x02040413) -> passes through as 0x02040413. addi x8,x8,-32 (0xFE040413) -> halfword 0x1401.
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0, out_word unchanged for 5 cycles. Releasing out_ready -> the word is taken once and the next input is accepted in the same cycle.
- Reset: pulse reset_n low while P=1 and out_valid=1 -> out_valid=0, idle=1, count_compressed=0. A following flush emits nothing.
